// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch unit: FSM state
// encoding, J opcode, fetch step and PC alignment helper.
package if_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_FLUSH = 2'd2,
        S_HOLD  = 2'd3
    } if_state_e;

    localparam logic [5:0] J_OPCODE   = 6'b000010;
    localparam logic [7:0] FETCH_STEP = 8'd4;

    function automatic logic [7:0] align_pc(input logic [7:0] pc);
        return pc & 8'hFC;
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: PC register, request FSM and decode-buffer output register.
// Define IFU_JFAST_EN to redirect the PC directly on fetched J instructions.
module if_fetch
    import if_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk_IFU,
    input  logic        rst_n_IFU,
    output logic        imem_req_IFU,
    output logic [7:0]  imem_addr_IFU,
    input  logic        imem_ack_IFU,
    input  logic [31:0] imem_data_IFU,
    input  logic        stall_IFU,
    input  logic        redirect_IFU,
    input  logic [7:0]  redirect_pc_IFU,
    output logic [31:0] instruction_IFU,
    output logic [7:0]  nextInst_IFU,
    output logic        valid_IFU
);

    if_state_e   r_state;
    if_state_e   w_state_nxt;
    logic [7:0]  r_pc;
    logic [7:0]  w_pc_nxt;
    logic [7:0]  r_tgt;
    logic [7:0]  w_tgt_nxt;
    logic [7:0]  r_next;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        w_valid_nxt;
    logic        w_load;
    logic        w_jump;
    logic [7:0]  w_seq_pc;
    logic [7:0]  w_redir_pc;

    assign w_seq_pc   = r_pc + FETCH_STEP;
    assign w_redir_pc = align_pc(redirect_pc_IFU);

`ifdef IFU_JFAST_EN
    assign w_jump = (imem_data_IFU[31:26] == J_OPCODE);
`else
    assign w_jump = 1'b0;
`endif

    always_ff @(posedge clk_IFU or negedge rst_n_IFU) begin
        if (!rst_n_IFU) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_pc stays on the outstanding address during a flush; the redirect target waits in r_tgt
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_tgt_nxt    = r_tgt;
        w_load       = 1'b0;
        w_valid_nxt  = r_valid & stall_IFU;
        imem_req_IFU = 1'b0;
        case (r_state)
            S_RESET: begin
                w_state_nxt = S_FETCH;
                if (redirect_IFU) begin
                    w_pc_nxt    = w_redir_pc;
                    w_valid_nxt = 1'b0;
                end
            end
            S_FETCH, S_FLUSH: begin
                imem_req_IFU = 1'b1;
                if (redirect_IFU) begin
                    w_valid_nxt = 1'b0;
                    if (imem_ack_IFU) begin
                        w_pc_nxt    = w_redir_pc;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_tgt_nxt   = w_redir_pc;
                        w_state_nxt = S_FLUSH;
                    end
                end else if (imem_ack_IFU) begin
                    if (r_state == S_FLUSH) begin
                        w_pc_nxt    = r_tgt;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_load      = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_pc_nxt    = w_jump ? {imem_data_IFU[5:0], 2'b00} : w_seq_pc;
                        w_state_nxt = stall_IFU ? S_HOLD : S_FETCH;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_IFU) begin
                    w_pc_nxt    = w_redir_pc;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_FETCH;
                end else if (!stall_IFU) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_RESET;
        endcase
    end

    always_ff @(posedge clk_IFU or negedge rst_n_IFU) begin
        if (!rst_n_IFU) begin
            r_pc    <= RESET_PC;
            r_tgt   <= RESET_PC;
            r_valid <= 1'b0;
            r_instr <= '0;
            r_next  <= '0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_tgt   <= w_tgt_nxt;
            r_valid <= w_valid_nxt;
            if (w_load) begin
                r_instr <= imem_data_IFU;
                r_next  <= w_seq_pc;
            end
        end
    end

    assign imem_addr_IFU   = r_pc;
    assign instruction_IFU = r_instr;
    assign nextInst_IFU    = r_next;
    assign valid_IFU       = r_valid;

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 8'h00, giving the first fetch address after reset.
REQ-002 The block SHALL have port clk_IFU, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n_IFU, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port imem_req_IFU, output, 1 bit: instruction-memory read request.
REQ-005 The block SHALL have port imem_addr_IFU, output, 8 bits: byte address of the request.
REQ-006 The block SHALL have port imem_ack_IFU, input, 1 bit: one-cycle pulse with read data valid.
REQ-007 The block SHALL have port imem_data_IFU, input, 32 bits: instruction word returned with ack.
REQ-008 The block SHALL have port stall_IFU, input, 1 bit: decode buffer cannot accept this cycle.
REQ-009 The block SHALL have ports redirect_IFU (input, 1 bit) and redirect_pc_IFU (input, 8 bits): branch/jump redirect request and target.
REQ-010 The block SHALL have port instruction_IFU, output, 32 bits: fetched word for the decode buffer.
REQ-011 The block SHALL have port nextInst_IFU, output, 8 bits: address of the fetched word plus 4.
REQ-012 The block SHALL have port valid_IFU, output, 1 bit: instruction_IFU/nextInst_IFU hold a live instruction.

Function
REQ-013 The FSM SHALL have states S_RESET, S_FETCH, S_FLUSH, S_HOLD; S_RESET SHALL go to S_FETCH after one cycle.
REQ-014 In S_FETCH and S_FLUSH, imem_req_IFU SHALL be 1 and imem_addr_IFU SHALL stay stable until ack; in S_RESET and S_HOLD, imem_req_IFU SHALL be 0.
REQ-015 On ack in S_FETCH, the block SHALL register data into instruction_IFU, set nextInst_IFU=pc+4, set valid_IFU=1, and set pc<=pc+4 (fetch-to-output latency 1 cycle after ack).
REQ-016 An output is consumed when valid_IFU=1 and stall_IFU=0; valid_IFU SHALL clear on consume unless a new ack loads in the same cycle.
REQ-017 After an ack, if stall_IFU=1 the FSM SHALL go to S_HOLD, otherwise it SHALL stay in S_FETCH and issue the next address back-to-back.
REQ-018 In S_HOLD, outputs SHALL be held; when stall_IFU=0 the FSM SHALL return to S_FETCH.
REQ-019 Redirect SHALL have top priority: pc<=redirect_pc_IFU with bits [1:0] forced to 00, valid_IFU<=0, and any same-cycle ack data discarded.
REQ-020 A redirect while a request is pending without ack SHALL go to S_FLUSH; the ack in S_FLUSH SHALL be dropped, then the FSM SHALL go to S_FETCH at the new pc.
REQ-021 A redirect in S_FLUSH SHALL overwrite the pending target; the last redirect wins.
REQ-022 pc arithmetic SHALL be 8-bit modulo: 8'hFC+4 = 8'h00, with no error flag.

Reset
REQ-023 Asserting rst_n_IFU=0 SHALL immediately force: state S_RESET, pc=RESET_PC, imem_req_IFU=0, valid_IFU=0, instruction_IFU=0, nextInst_IFU=0.
REQ-024 Reset mid-request SHALL abandon the request, and an ack arriving during or after reset release SHALL be ignored until S_FETCH has asserted a new request.

Configuration
REQ-025 With IFU_JFAST_EN defined, on an accepted ack whose bits [31:26]=6'b000010 (J), the block SHALL set pc<={data[5:0],2'b00} instead of pc+4, while nextInst_IFU stays fetch address+4.
REQ-026 Without IFU_JFAST_EN, J instructions SHALL be fetched sequentially and only redirect_IFU SHALL change flow.

Structure
REQ-027 The FSM state typedef, the state encodings, the J opcode constant and the fetch step (4) SHALL reside in a shared package, if_pkg.
REQ-028 No sub-module SHALL be used; pc register, FSM and output register SHALL stay in if_fetch.

Verification
REQ-029 The bench SHALL check: reset release with RESET_PC=8'h10 and ack every 2nd cycle -> addresses 10,14,18, nextInst_IFU 14,18,1C, no gaps besides memory latency.
REQ-030 The bench SHALL check: stall_IFU=1 for 3 cycles with valid_IFU=1 -> req=0, outputs unchanged, fetch resumes at the next address on release.
REQ-031 The bench SHALL check: redirect to 8'h43 while a request to 8'h20 is pending -> S_FLUSH, the 0x20 data never appears on valid_IFU, next address 8'h40.
REQ-032 The bench SHALL check: redirect coincident with ack -> the ack data is discarded and valid_IFU=0 next cycle.
REQ-033 The bench SHALL check: fetch from 8'hFC -> nextInst_IFU=8'h00 and the next request address is 8'h00.
REQ-034 The bench SHALL check: with IFU_JFAST_EN, word 32'h0800_0005 at 8'h08 -> next request 8'h14 and nextInst_IFU=8'h0C; without it, next request 8'h0C.
